// File: rtl/byte_sequencer_pkg.sv
// byte_sequencer_pkg
// Shared definitions for the byte sequencer and the neighbouring narrow-bus
// stages: access-size encodings, the sequencer state encoding, the latched
// request record and byte-count helpers.
// Optional feature macro: BYTE_SEQUENCER_ALIGN_CHECK_EN adds the ERR state.
package byte_sequencer_pkg;

    localparam logic [1:0] SIZ_BYTE  = 2'd0;
    localparam logic [1:0] SIZ_HALF  = 2'd1;
    localparam logic [1:0] SIZ_WORD  = 2'd2;
    localparam logic [1:0] SIZ_DWORD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_DONE
`ifdef BYTE_SEQUENCER_ALIGN_CHECK_EN
        ,ST_ERR
`endif
    } state_t;

    // Master request as latched on acceptance.
    typedef struct packed {
        logic [63:0] adr;
        logic [63:0] dat;
        logic [1:0]  siz;
        logic        sgn;
        logic        we;
    } req_t;

    // Number of bytes in an access of the given size: 1<<siz.
    function automatic logic [3:0] byte_count(input logic [1:0] siz);
        return 4'd1 << siz;
    endfunction

    // Index of the last byte of an access (also the low-address alignment mask).
    function automatic logic [2:0] last_idx(input logic [1:0] siz);
        logic [3:0] n;
        n = byte_count(siz) - 4'd1;
        return n[2:0];
    endfunction

endpackage

// File: rtl/byte_extend.sv
// byte_extend
// Combinational sign/zero extension of a right-justified 8/16/32/64-bit value
// to 64 bits.
// Ports:
//   din  - right-justified value; bits above the access size are ignored
//   siz  - access size (SIZ_BYTE..SIZ_DWORD)
//   sgn  - sign-extend when set, zero-extend otherwise
//   dout - 64-bit extended result
module byte_extend
    import byte_sequencer_pkg::*;
(
    input  logic [63:0] din,
    input  logic [1:0]  siz,
    input  logic        sgn,
    output logic [63:0] dout
);

    always_comb begin
        dout = din;
        case (siz)
            SIZ_BYTE: dout = {{56{sgn & din[7]}},  din[7:0]};
            SIZ_HALF: dout = {{48{sgn & din[15]}}, din[15:0]};
            SIZ_WORD: dout = {{32{sgn & din[31]}}, din[31:0]};
            default:  dout = din;
        endcase
    end

endmodule

// File: rtl/byte_sequencer.sv
// byte_sequencer
// Splits one 8/16/32/64-bit master access into single-byte slave cycles at
// consecutive little-endian addresses; assembles and extends read data.
// Optional feature macro: BYTE_SEQUENCER_ALIGN_CHECK_EN (misalignment error,
// adds the m_err_o port).
// Ports:
//   clk_i, reset_i            - clock, asynchronous active-high reset
//   m_adr_i/m_dat_i/m_siz_i   - master address, write data, size
//   m_signed_i/m_we_i         - read sign-extension, write enable
//   m_cyc_i/m_stb_i           - master cycle / strobe
//   m_ack_o/m_dat_o           - completion pulse and extended read data
//   m_err_o                   - misalignment pulse (macro only)
//   s_*                       - byte-wide slave cycle; s_dat_i[7:0] used
// All outputs are registered.
module byte_sequencer
    import byte_sequencer_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [63:0] m_adr_i,
    input  logic        m_cyc_i,
    input  logic [63:0] m_dat_i,
    input  logic        m_signed_i,
    input  logic [1:0]  m_siz_i,
    input  logic        m_stb_i,
    input  logic        m_we_i,
    output logic        m_ack_o,
    output logic [63:0] m_dat_o,
    output logic [63:0] s_adr_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic        s_signed_o,
    output logic [1:0]  s_siz_o,
    output logic [63:0] s_dat_o,
    input  logic        s_ack_i,
    input  logic [63:0] s_dat_i
`ifdef BYTE_SEQUENCER_ALIGN_CHECK_EN
    ,output logic       m_err_o
`endif
);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    req_t        req_q, req_d;
    logic [63:0] asm_q, asm_d;
    logic [63:0] asm_nxt;
    logic [63:0] ext_out;

    logic        m_ack_d;
    logic [63:0] m_dat_d;
    logic [63:0] s_adr_d;
    logic        s_cyc_d;
    logic        s_we_d;
    logic [63:0] s_dat_d;
`ifdef BYTE_SEQUENCER_ALIGN_CHECK_EN
    logic        m_err_d;
`endif

    // Only the low byte of the slave bus carries data.
    logic unused_sdat;
    assign unused_sdat = ^s_dat_i[63:8];

    assign s_signed_o = 1'b0;
    assign s_siz_o    = SIZ_BYTE;

    // Assembly register with the current slave byte merged in; kept apart
    // from the FSM so the extender sees the final byte on the last ack.
    always_comb begin
        asm_nxt = asm_q;
        asm_nxt[{cnt_q, 3'b000} +: 8] = s_dat_i[7:0];
    end

    byte_extend u_ext (
        .din  (asm_nxt),
        .siz  (req_q.siz),
        .sgn  (req_q.sgn),
        .dout (ext_out)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        asm_d   = asm_q;
        m_ack_d = 1'b0;
        m_dat_d = '0;
`ifdef BYTE_SEQUENCER_ALIGN_CHECK_EN
        m_err_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (m_cyc_i && m_stb_i) begin
                    req_d = '{adr: m_adr_i, dat: m_dat_i, siz: m_siz_i,
                              sgn: m_signed_i, we: m_we_i};
                    cnt_d = 3'd0;
                    asm_d = '0;
                    state_d = ST_BUS;
`ifdef BYTE_SEQUENCER_ALIGN_CHECK_EN
                    if ((m_adr_i[2:0] & last_idx(m_siz_i)) != 3'd0) begin
                        state_d = ST_ERR;
                        m_err_d = 1'b1;
                    end
`endif
                end
            end
            ST_BUS: begin
                // Abort wins over an ack in the same cycle.
                if (!m_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (s_ack_i) begin
                    if (!req_q.we) asm_d = asm_nxt;
                    if (cnt_q == last_idx(req_q.siz)) begin
                        state_d = ST_DONE;
                        m_ack_d = 1'b1;
                        m_dat_d = req_q.we ? 64'd0 : ext_out;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
`ifdef BYTE_SEQUENCER_ALIGN_CHECK_EN
            ST_ERR:  state_d = ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase

        // Slave outputs follow the next state so they are registered yet
        // valid from the first BUS cycle.
        s_cyc_d = (state_d == ST_BUS);
        s_adr_d = '0;
        s_we_d  = 1'b0;
        s_dat_d = '0;
        if (state_d == ST_BUS) begin
            s_adr_d = req_d.adr + {61'd0, cnt_d};
            s_we_d  = req_d.we;
            s_dat_d = {56'd0, req_d.dat[{cnt_d, 3'b000} +: 8]};
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            asm_q   <= '0;
            m_ack_o <= 1'b0;
            m_dat_o <= '0;
            s_adr_o <= '0;
            s_cyc_o <= 1'b0;
            s_stb_o <= 1'b0;
            s_we_o  <= 1'b0;
            s_dat_o <= '0;
`ifdef BYTE_SEQUENCER_ALIGN_CHECK_EN
            m_err_o <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            asm_q   <= asm_d;
            m_ack_o <= m_ack_d;
            m_dat_o <= m_dat_d;
            s_adr_o <= s_adr_d;
            s_cyc_o <= s_cyc_d;
            s_stb_o <= s_cyc_d;
            s_we_o  <= s_we_d;
            s_dat_o <= s_dat_d;
`ifdef BYTE_SEQUENCER_ALIGN_CHECK_EN
            m_err_o <= m_err_d;
`endif
        end
    end

endmodule
